// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states, operand width and sign helper shared by the multiply/divide unit and the decoder
package muldiv_pkg;
   localparam int XLEN = 32;
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_t;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
      return s ? -v : v;
   endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide with architectural HI/LO registers
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, op, a, b    request, op code and operands (rd1/rd2), taken only while idle
//   busy, done         op in flight / one-cycle pulse when HI/LO were just written by an op
//   hi, lo             HI/LO registers
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   state_t state, state_d;
   logic [2*XLEN-1:0] acc, prod;
   logic [XLEN-1:0] opr;
   logic [4:0] cnt;
   logic is_div, neg_q, neg_r, go, sa, sb;
   logic [XLEN:0] sum, t, d;
   always_comb begin
      go      = start && state == IDLE && !op[2];
      sa      = (op == OP_MULT || op == OP_DIV) && a[XLEN-1];
      sb      = (op == OP_MULT || op == OP_DIV) && b[XLEN-1];
      state_d = state == IDLE ? (go ? RUN : IDLE) : state == RUN ? (&cnt ? FIN : RUN) : IDLE;
      busy    = state != IDLE;
      // multiply: acc = {partial product, remaining multiplier bits}
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opr} : '0);
      // divide: acc = {remainder, remaining dividend / quotient bits}
      t       = acc[2*XLEN-1:XLEN-1];
      d       = t - {1'b0, opr};
      prod    = neg_q ? -acc : acc;
   end
   always_ff @(posedge clk) state <= reset ? IDLE : state_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= state == FIN;
         if (state == IDLE && start && op == OP_MTHI) hi <= a;
         if (state == IDLE && start && op == OP_MTLO) lo <= a;
         if (state == FIN) begin
            hi <= is_div ? mag(acc[2*XLEN-1:XLEN], neg_r) : prod[2*XLEN-1:XLEN];
            lo <= is_div ? mag(acc[XLEN-1:0], neg_q) : prod[XLEN-1:0];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (go) begin
         acc    <= {{XLEN{1'b0}}, mag(a, sa)};
         opr    <= mag(b, sb);
         cnt    <= '0;
         is_div <= op[1];
         // a zero divisor keeps the all-ones quotient; the remainder then equals a
         neg_q  <= (sa ^ sb) && (!op[1] || b != '0);
         neg_r  <= sa;
      end else if (state == RUN) begin
         cnt <= cnt + 5'd1;
         acc <= is_div ? (d[XLEN] ? {t[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {d[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                       : {sum, acc[XLEN-1:1]};
      end
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the register file. It takes rd1/rd2 as operands for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It holds the 64-bit result in HI/LO for MFHI/MFLO. The writeback mux reads `hi` and `lo` directly, and control stalls the pipeline on `busy`.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  request; accepted only while `busy`=0.
- `op`  in  3  operation code (values in the shared package), sampled with `start`.
- `a`  in  32  operand A / dividend / MTHI-MTLO data (driven from rd1).
- `b`  in  32  operand B / divisor (driven from rd2).
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO were just updated by a multi-cycle op.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **States:**
  - IDLE: accepts requests.
  - RUN: a 5-bit counter steps through 32 iterations.
  - FIN: sign fix-up and HI/LO write. Then return to IDLE.
- **IDLE with `start`=1:**
  - MULT/MULTU/DIV/DIVU latch the operands and go to RUN.
  - Signed ops latch |a| and |b| and record the result signs.
  - MTHI writes `hi`<=`a` at that edge; MTLO writes `lo`<=`a` at that edge. The unit stays in IDLE, `busy` stays 0 and `done` stays 0.
  - Undefined op codes are ignored.
- **Multiply:** unsigned shift-add, one multiplier bit per cycle, 64-bit product.
  - MULT negates the 64-bit product in FIN when the operand signs differ.
- **Divide:** restoring divide, one quotient bit per cycle.
  - Quotient goes to LO, remainder to HI.
  - DIV truncates toward zero. The remainder takes the sign of the dividend.
- **Divide by zero (DIV or DIVU, `b`=0):** LO=FFFFFFFF and HI=`a`, with normal latency.
- **DIV 80000000 / FFFFFFFF:** LO=80000000, HI=00000000.
- **`start` while `busy`=1:** ignored for all ops, including MTHI/MTLO. Operands and the in-flight op are unaffected.
- **Reset (any state, including mid-operation):** returns to IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0. No `done` pulse occurs for an aborted op.
- **Internal width:** 64-bit accumulator/remainder register plus 32-bit operand register. No intermediate is wider than 65 bits.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE.
- **Multi-cycle op sampled at edge n:**
  - `busy`=1 from after edge n through edge n+32.
  - RUN iterations occur on edges n+1 … n+32.
  - FIN at edge n+33 updates `hi`/`lo` and sets `done`=1 and `busy`=0.
- **Latency:** 34 edges including the sampling edge. `done` is high for exactly the one cycle after edge n+33.
- **Back-to-back:** a new `start` is accepted in the same cycle `done` is high, i.e. at edge n+34.
- **MTHI/MTLO:** zero-latency register write. The new value is visible on `hi`/`lo` after the sampling edge.
- **Outputs:** `hi`/`lo` change only at FIN, on MTHI/MTLO, or on reset. They hold their old values throughout RUN.

## Structure
- **Shared package `muldiv_pkg`:**
  - op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - state enum: IDLE, RUN, FIN.
  - `XLEN` constant.
  - The decoder uses the same package to generate `op`.
- **Modules:** single module. The datapath is small enough that no sub-module is needed.

## Test plan
- **Reset, then MULTU FFFFFFFF×FFFFFFFF at edge n:** `busy` for 33 cycles; after edge n+33 `done`=1, `hi`=FFFFFFFE, `lo`=00000001.
- **MULT FFFFFFFD×00000007:** `hi`=FFFFFFFF, `lo`=FFFFFFEB.
- **Division results:**
  - DIV FFFFFFF9÷00000002 gives `lo`=FFFFFFFD, `hi`=FFFFFFFF.
  - DIVU 00000007÷00000002 gives `lo`=00000003, `hi`=00000001.
- **Divide corner cases:**
  - DIV 00001234÷0 gives `lo`=FFFFFFFF, `hi`=00001234, 34-edge latency.
  - DIV 80000000÷FFFFFFFF gives `lo`=80000000, `hi`=00000000.
- **Busy/MTHI-MTLO handling:**
  - MTLO 0000ABCD while `busy`=1 gives no change to `lo` and the running result is unaffected.
  - MTHI 12345678 while idle gives `hi`=12345678 next cycle, `done`=0.
- **Reset mid-operation:** assert `reset` 10 cycles into a DIVU. `busy`=0, `hi`=`lo`=0 after that edge, and no `done` pulse follows. A subsequent MULTU 2×3 yields `lo`=6, `hi`=0.
